// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - memory-stage request/response bundle between pipeline and data memory
interface dmem_responder_if #(
  parameter int N = 64
);
  logic         memRead_M;
  logic         memWrite_M;
  logic [N-1:0] address_M;
  logic [N-1:0] writeData_M;
  logic [N-1:0] readData_M;
  logic         ready_M;
  logic         busy_M;
  logic         excAlign_M;
  logic         excRange_M;
  logic         excOp_M;

  // Pipeline side: issues requests, consumes completion and exception status.
  modport master (
    output memRead_M, memWrite_M, address_M, writeData_M,
    input  readData_M, ready_M, busy_M, excAlign_M, excRange_M, excOp_M
  );

  // Memory side: consumes requests, produces completion and exception status.
  modport slave (
    input  memRead_M, memWrite_M, address_M, writeData_M,
    output readData_M, ready_M, busy_M, excAlign_M, excRange_M, excOp_M
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory responder with synchronous exception flags
// A request is latched on the IDLE edge where it is seen, the array is touched
// on the edge entering DONE, and ready/flags/readData are registered outputs.
module dmem_responder #(
  parameter int N     = 64,
  parameter int WORDS = 32,
  parameter int LAT   = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;

  logic [N-1:0]  mem [WORDS];

  // Request as presented on the bus this cycle.
  logic          req;
  logic          accept;
  logic          live_align;
  logic          live_range;
  logic          live_op;

  // Request captured at acceptance; the pipeline may change its inputs afterwards.
  logic [AW-1:0] lat_idx;
  logic [N-1:0]  lat_data;
  logic          lat_write;
  logic          lat_align;
  logic          lat_range;
  logic          lat_op;

  // Values actually used on the DONE-entry edge (live when LAT=1, latched otherwise).
  logic          enter_done;
  logic [AW-1:0] acc_idx;
  logic [N-1:0]  acc_data;
  logic          acc_write;
  logic          acc_align;
  logic          acc_range;
  logic          acc_op;
  logic          acc_exc;

  // Registered outputs.
  logic [N-1:0]  rdata_q;
  logic          ready_q;
  logic          align_q;
  logic          range_q;
  logic          op_q;

  assign req        = bus.memRead_M | bus.memWrite_M;
  assign accept     = (state == IDLE) & req;
  assign live_align = (bus.address_M[2:0] != 3'b000);
  // Whole upper address is compared so that large addresses never alias into the array.
  assign live_range = (bus.address_M[N-1:3] >= (N-3)'(WORDS));
  assign live_op    = bus.memRead_M & bus.memWrite_M;

  assign enter_done = ((state == BUSY) && (cnt == CW'(1))) || (accept && (LAT == 1));

  // With LAT=1 acceptance and DONE entry share an edge, so the live request is used directly.
  always_comb begin
    acc_idx   = lat_idx;
    acc_data  = lat_data;
    acc_write = lat_write;
    acc_align = lat_align;
    acc_range = lat_range;
    acc_op    = lat_op;
    if (state == IDLE) begin
      acc_idx   = bus.address_M[AW+2:3];
      acc_data  = bus.writeData_M;
      acc_write = bus.memWrite_M;
      acc_align = live_align;
      acc_range = live_range;
      acc_op    = live_op;
    end
  end

  assign acc_exc = acc_align | acc_range | acc_op;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: IDLE -> (BUSY ->) DONE -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = (LAT == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latency counter: loaded with LAT-1 on acceptance, counts down through BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CW'(LAT - 1);
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Capture request and its classification on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      lat_align <= 1'b0;
      lat_range <= 1'b0;
      lat_op    <= 1'b0;
    end else if (accept) begin
      lat_idx   <= bus.address_M[AW+2:3];
      lat_data  <= bus.writeData_M;
      lat_write <= bus.memWrite_M;
      lat_align <= live_align;
      lat_range <= live_range;
      lat_op    <= live_op;
    end
  end

  // Array storage: written only by a clean store on DONE entry; reset clears every word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (enter_done && acc_write && !acc_exc) begin
      mem[acc_idx] <= acc_data;
    end
  end

  // Completion outputs: ready and flags live for the DONE cycle, readData holds until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
      align_q <= 1'b0;
      range_q <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      ready_q <= enter_done;
      align_q <= enter_done & acc_align;
      range_q <= enter_done & acc_range;
      op_q    <= enter_done & acc_op;
      if (enter_done) begin
        rdata_q <= (acc_exc || acc_write) ? '0 : mem[acc_idx];
      end
    end
  end

  assign bus.readData_M = rdata_q;
  assign bus.ready_M    = ready_q;
  assign bus.excAlign_M = align_q;
  assign bus.excRange_M = range_q;
  assign bus.excOp_M    = op_q;
  assign bus.busy_M     = (state == BUSY) | accept;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed bench for dmem_responder at LAT=1, 2 and 5
module tb_dmem_responder;
  localparam int N     = 64;
  localparam int WORDS = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]   rd;
  logic [2:0]   wr;
  logic [N-1:0] ad [3];
  logic [N-1:0] wd [3];
  logic [N-1:0] rdata [3];
  logic [2:0]   rdy;
  logic [2:0]   bsy;
  logic [2:0]   ea;
  logic [2:0]   er;
  logic [2:0]   eo;

  logic [N-1:0] model [3][WORDS];

  int checks   = 0;
  int failures = 0;

  dmem_responder_if #(.N(N)) bus0 ();
  dmem_responder_if #(.N(N)) bus1 ();
  dmem_responder_if #(.N(N)) bus2 ();

  dmem_responder #(.N(N), .WORDS(WORDS), .LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.N(N), .WORDS(WORDS), .LAT(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dmem_responder #(.N(N), .WORDS(WORDS), .LAT(5)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus0.memRead_M   = rd[0];
  assign bus0.memWrite_M  = wr[0];
  assign bus0.address_M   = ad[0];
  assign bus0.writeData_M = wd[0];
  assign bus1.memRead_M   = rd[1];
  assign bus1.memWrite_M  = wr[1];
  assign bus1.address_M   = ad[1];
  assign bus1.writeData_M = wd[1];
  assign bus2.memRead_M   = rd[2];
  assign bus2.memWrite_M  = wr[2];
  assign bus2.address_M   = ad[2];
  assign bus2.writeData_M = wd[2];

  assign rdata[0] = bus0.readData_M;
  assign rdata[1] = bus1.readData_M;
  assign rdata[2] = bus2.readData_M;
  assign rdy = {bus2.ready_M,    bus1.ready_M,    bus0.ready_M};
  assign bsy = {bus2.busy_M,     bus1.busy_M,     bus0.busy_M};
  assign ea  = {bus2.excAlign_M, bus1.excAlign_M, bus0.excAlign_M};
  assign er  = {bus2.excRange_M, bus1.excRange_M, bus0.excRange_M};
  assign eo  = {bus2.excOp_M,    bus1.excOp_M,    bus0.excOp_M};

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
  endfunction

  task automatic check_eq(string tag, logic [N-1:0] got, logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < WORDS; i++)
        model[k][i] = '0;
  endtask

  // One transaction on instance k, checked against the word-array model.
  task automatic do_access(int k, bit r, bit w, logic [N-1:0] a, logic [N-1:0] d, output logic [N-1:0] got_data);
    int           lat;
    int           seen;
    bit           e_al;
    bit           e_rg;
    bit           e_op;
    logic [N-1:0] exp;
    int           idx;
    lat  = lat_of(k);
    e_al = (a % 8) != 0;
    e_rg = (a / 8) >= WORDS;
    e_op = r && w;
    idx  = int'((a / 8) % WORDS);
    if (e_al || e_rg || e_op) begin
      exp = '0;
    end else if (w) begin
      model[k][idx] = d;
      exp = '0;
    end else begin
      exp = model[k][idx];
    end
    @(negedge clk);
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
    #1 check_eq($sformatf("busy_req%0d", k), N'(bsy[k]), N'(1));
    seen = 0;
    for (int c = 1; c <= lat + 3; c++) begin
      @(negedge clk);
      if (rdy[k]) begin
        seen = c;
        break;
      end
      check_eq($sformatf("busy_wait%0d", k), N'(bsy[k]), N'(1));
    end
    check_eq($sformatf("latency%0d", k), N'(seen), N'(lat));
    got_data = rdata[k];
    if (seen != 0) begin
      check_eq($sformatf("rdata%0d", k), rdata[k], exp);
      check_eq($sformatf("flags%0d", k), N'({ea[k], er[k], eo[k]}), N'({e_al, e_rg, e_op}));
      check_eq($sformatf("busy_done%0d", k), N'(bsy[k]), N'(0));
    end
    rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = {$urandom, $urandom}; wd[k] = {$urandom, $urandom};
    @(negedge clk);
    check_eq($sformatf("ready_once%0d", k), N'(rdy[k]), N'(0));
    check_eq($sformatf("rdata_hold%0d", k), rdata[k], exp);
  endtask

  // Read request held high across several completions: one access per LAT+1 cycles.
  task automatic held(int k);
    int lat;
    int cnt;
    bit prev;
    lat  = lat_of(k);
    cnt  = 0;
    prev = 1'b0;
    @(negedge clk);
    rd[k] = 1'b1; wr[k] = 1'b0; ad[k] = 64'h10; wd[k] = '0;
    for (int i = 1; i <= 4 * (lat + 1); i++) begin
      @(negedge clk);
      if (rdy[k]) begin
        cnt++;
        check_eq($sformatf("no_b2b%0d", k), N'(prev), N'(0));
        check_eq($sformatf("held_data%0d", k), rdata[k], model[k][2]);
      end
      prev = rdy[k];
    end
    rd[k] = 1'b0;
    check_eq($sformatf("held_count%0d", k), N'(cnt), N'(4));
    @(negedge clk);
  endtask

  // Store to 0x18 aborted by reset right after acceptance.
  task automatic reset_mid(int k);
    logic [N-1:0] got;
    @(negedge clk);
    wr[k] = 1'b1; rd[k] = 1'b0; ad[k] = 64'h18; wd[k] = {$urandom, $urandom};
    @(posedge clk);
    #1 reset = 1'b1;
    wr[k] = 1'b0;
    clear_model();
    #1;
    check_eq($sformatf("rst_ready%0d", k), N'(rdy[k]), N'(0));
    check_eq($sformatf("rst_flags%0d", k), N'({ea[k], er[k], eo[k]}), N'(0));
    check_eq($sformatf("rst_busy%0d", k), N'(bsy[k]), N'(0));
    check_eq($sformatf("rst_rdata%0d", k), rdata[k], '0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < lat_of(k) + 2; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_noready%0d", k), N'(rdy[k]), N'(0));
    end
    do_access(k, 1'b1, 1'b0, 64'h18, '0, got);
    check_eq($sformatf("rst_load%0d", k), got, '0);
  endtask

  initial begin
    logic [N-1:0] got;
    logic [N-1:0] a;
    logic [N-1:0] d;
    int           sel;
    int           asel;
    bit           r;
    bit           w;
    reset = 1'b1;
    rd = '0;
    wr = '0;
    for (int k = 0; k < 3; k++) begin
      ad[k] = '0;
      wd[k] = '0;
    end
    clear_model();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("reset_rdata%0d", k), rdata[k], '0);
      check_eq($sformatf("reset_out%0d", k), N'({rdy[k], bsy[k], ea[k], er[k], eo[k]}), N'(0));
    end
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      do_access(k, 1'b0, 1'b1, 64'h10, 64'h1122334455667788, got);
      do_access(k, 1'b1, 1'b0, 64'h10, '0, got);
      check_eq($sformatf("dir_load%0d", k), got, 64'h1122334455667788);
      do_access(k, 1'b0, 1'b1, 64'h08, 64'hA5A5_0000_5A5A_0001, got);
      do_access(k, 1'b1, 1'b0, 64'h0C, '0, got);
      do_access(k, 1'b1, 1'b0, 64'h08, '0, got);
      check_eq($sformatf("dir_after_align%0d", k), got, 64'hA5A5_0000_5A5A_0001);
      do_access(k, 1'b0, 1'b1, 64'h100, 64'hDEAD_BEEF_0000_0001, got);
      do_access(k, 1'b1, 1'b0, 64'h00, '0, got);
      check_eq($sformatf("dir_no_alias%0d", k), got, '0);
      do_access(k, 1'b0, 1'b1, 64'h08, '0, got);
      do_access(k, 1'b1, 1'b1, 64'h08, 64'hFF, got);
      do_access(k, 1'b1, 1'b0, 64'h08, '0, got);
      check_eq($sformatf("dir_op_nowrite%0d", k), got, '0);
      held(k);
      for (int t = 0; t < 30; t++) begin
        sel  = $urandom_range(0, 9);
        asel = $urandom_range(0, 9);
        r = (sel <= 3) || (sel >= 8);
        w = (sel >= 4) && (sel <= 8);
        if (asel < 8)       a = N'($urandom_range(0, WORDS - 1)) * 8;
        else if (asel == 8) a = N'($urandom_range(0, WORDS - 1)) * 8 + N'($urandom_range(1, 7));
        else                a = (N'(WORDS) + N'($urandom_range(0, 100000))) * 8;
        d = {$urandom, $urandom};
        do_access(k, r, w, a, d, got);
      end
      reset_mid(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that serves the memory stage of the LEGv8 core with exceptions.
- Accepts the address (ALU result) and store data produced by execute, together with the memRead/memWrite controls.
- Returns load data after a fixed, parameterised latency, with a one-cycle ready pulse and a busy/stall indication toward the pipeline.
- Detects misaligned, out-of-range and conflicting accesses and reports them as synchronous exception flags alongside ready.

Parameters:
- N, 64: data and address width in bits.
- WORDS, 32: number of N-bit words in the array. Power of two, minimum 2.
- LAT, 2: cycles from the accepting edge to ready. Minimum 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- memRead_M  input  1  load request.
- memWrite_M  input  1  store request.
- address_M  input  N  byte address.
- writeData_M  input  N  store data.
- readData_M  output  N  load data, valid while ready_M is high.
- ready_M  output  1  one-cycle completion pulse.
- busy_M  output  1  stall request to the pipeline.
- excAlign_M  output  1  misaligned access flag, valid while ready_M is high.
- excRange_M  output  1  out-of-range access flag, valid while ready_M is high.
- excOp_M  output  1  memRead and memWrite both asserted, valid while ready_M is high.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE and the counter to 0.
  - readData_M = 0; ready_M and all exception flags = 0.
  - All array words = 0.
  - Any in-flight store is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - A request exists when memRead_M | memWrite_M is high.
  - On a clock edge with a request present, the block latches address, write data, op and exception classification.
  - Then LAT=1 goes to DONE; LAT>1 goes to BUSY with cnt = LAT-1.
- BUSY: cnt decrements each edge. The edge at which cnt==1 transitions to DONE.
- DONE:
  - ready_M = 1 for exactly one cycle, then unconditional return to IDLE.
  - Requests presented during DONE are ignored. Back-to-back accesses therefore have a one-cycle IDLE gap minimum; total occupancy is LAT+1 cycles.
- busy_M (combinational) = (state==BUSY) | (state==IDLE & request).
  - busy_M is low in DONE, so the pipeline advances on the ready cycle.
- The pipeline holds request inputs stable until ready. Changes after acceptance have no effect, because latched values are used.
- Classification at acceptance:
  - excAlign: address[2:0] != 0.
  - excRange: address[N-1:3] >= WORDS.
  - excOp: memRead_M & memWrite_M.
  - Multiple flags may be set simultaneously.
  - Any flag set: no array read or write, readData_M = 0.
- Array access, performed on the edge entering DONE:
  - Index = latched address[3+log2(WORDS)-1:3].
  - Store: the word is written with latched data; readData_M = 0.
  - Load: readData_M = word contents. readData_M holds its value after DONE until the next completion or reset.
- Exception flags and ready_M are registered, asserted only in DONE, and 0 otherwise.
- Address wrap-around: none. Any address beyond the array raises excRange; no aliasing.
- Reset asserted during BUSY or DONE aborts the access with no array update, no ready pulse and no flags.

Test Plan:
- LAT=2: reset, then store 0x1122334455667788 at address 0x10, then load address 0x10 → busy_M high on the request cycle plus one BUSY cycle; ready_M pulses 2 cycles after acceptance; load returns 0x1122334455667788 with all flags 0.
- Load from address 0x0C → ready after LAT; excAlign=1; readData_M=0; memory unchanged (a following load at 0x08 returns its prior value).
- Store to address 0x100 (word 32, WORDS=32) → excRange=1; a subsequent load of 0x00 returns 0, showing no aliasing.
- memRead_M=memWrite_M=1 at address 0x08 with data 0xFF → excOp=1, no write; a subsequent load of 0x08 returns 0.
- Request held continuously across DONE → exactly one access per LAT+1 cycles; ready_M is never high in two consecutive cycles.
- Store to 0x18 with reset pulsed mid-BUSY → no ready pulse, FSM in IDLE; a subsequent load of 0x18 returns 0. Repeat all scenarios with LAT=1 (ready on the cycle after acceptance) and LAT=5.
